// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer.
package lsu_pkg;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        RESP
    } state_e;

endpackage

// File: rtl/lsu_ctrl_if.sv
// Core request/response and RAM port bundle for the load/store sequencer.
// slave is the sequencer's view; master is the core-plus-RAM view.
interface lsu_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_we, mem_wd
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_a, mem_we, mem_wd
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: extracts and extends load data from a RAM word and
// merges sub-word store data into a RAM word for read-modify-write.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr,
    input  size_e       size,
    input  logic        uns,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [BYTE_W-1:0] byte_f;
    logic [HALF_W-1:0] half_f;

    // Select the addressed lane(s), extend for loads, splice in store data.
    always_comb begin
        // NOTE: every output gets a default up front so no path infers a latch.
        ld_data = word;
        st_word = wdata;
        byte_f  = word[{addr, 3'b000} +: BYTE_W];
        half_f  = word[{addr[1], 4'b0000} +: HALF_W];
        case (size)
            SZ_B: begin
                ld_data = {{(WORD_W-BYTE_W){byte_f[BYTE_W-1] & ~uns}}, byte_f};
                st_word = word;
                st_word[{addr, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
            end
            SZ_H: begin
                ld_data = {{(WORD_W-HALF_W){half_f[HALF_W-1] & ~uns}}, half_f};
                st_word = word;
                st_word[{addr[1], 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: turns core byte/half/word requests into word-aligned
// RAM cycles, with read-modify-write for sub-word stores.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_SIZE = 512
)(
    input  logic       clk,
    input  logic       rst_n,
    lsu_ctrl_if.slave  bus
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_SIZE * 4);

    state_e      state;
    size_e       size_q;
    logic        uns_q;
    logic [1:0]  addr_lo;
    logic [31:0] wdata_q;
    logic        ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [31:0] mem_a_q;
    logic        mem_we_q;
    logic [31:0] mem_wd_q;

    size_e       req_size;
    logic        misalign;
    logic        req_err;
    logic [31:0] ld_data;
    logic [31:0] st_word;

    assign req_size = size_e'(bus.req_size);
    assign misalign = (req_size == SZ_H && bus.req_addr[0]) ||
                      (req_size == SZ_W && bus.req_addr[1:0] != 2'b00);
    assign req_err  = misalign || (req_size == SZ_X) || (bus.req_addr >= ADDR_LIMIT);

    lsu_align u_align (
        .addr    (addr_lo),
        .size    (size_q),
        .uns     (uns_q),
        .word    (bus.mem_rd),
        .wdata   (wdata_q),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    // Sequencer FSM with all outputs registered; reset drops any pending access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            addr_lo     <= 2'b00;
            wdata_q     <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_a_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_wd_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        ready_q     <= 1'b0;
                        size_q      <= req_size;
                        uns_q       <= bus.req_unsigned;
                        addr_lo     <= bus.req_addr[1:0];
                        wdata_q     <= bus.req_wdata;
                        mem_a_q     <= {bus.req_addr[31:2], 2'b00};
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        if (req_err) begin
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state       <= RESP;
                        end else if (!bus.req_we) begin
                            state <= RD;
                        end else if (req_size == SZ_W) begin
                            mem_we_q <= 1'b1;
                            mem_wd_q <= bus.req_wdata;
                            state    <= WR;
                        end else begin
                            state <= RMW_RD;
                        end
                    end
                end
                RD: begin
                    rsp_rdata_q <= ld_data;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RMW_RD: begin
                    mem_wd_q <= st_word;
                    mem_we_q <= 1'b1;
                    state    <= WR;
                end
                WR: begin
                    mem_we_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_a     = mem_a_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wd    = mem_wd_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: stimulus pushes expected responses and RAM
// writes (with their cycle) into queues; negedge monitors pop and compare.
module tb_lsu_ctrl;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];
    logic [31:0] ram [0:511];

    lsu_ctrl_if bus ();

    lsu_ctrl #(.MEM_SIZE(512)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: combinational read, posedge write of the whole word.
    assign bus.mem_rd = ram[bus.mem_a[10:2]];
    always @(posedge clk) if (bus.mem_we) ram[bus.mem_a[10:2]] <= bus.mem_wd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            if (rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got rsp_valid with rdata 0x%08h expected none (cycle %0d)", bus.rsp_rdata, cyc);
            end else begin
                rsp_t e;
                e = rsp_q.pop_front();
                check("rsp_rdata", bus.rsp_rdata, e.rdata);
                check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                check("rsp_cycle", cyc, e.cyc);
                check("ready_in_resp", 32'(bus.req_ready), 32'd0);
            end
        end
    end

    // RAM write monitor.
    always @(negedge clk) begin
        if (rst_n && bus.mem_we) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got mem_we at 0x%08h data 0x%08h expected none (cycle %0d)", bus.mem_a, bus.mem_wd, cyc);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                check("mem_a", bus.mem_a, w.addr);
                check("mem_wd", bus.mem_wd, w.data);
                check("wr_cycle", cyc, w.cyc);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                         input logic exp_wr, input int wr_lat, input logic [31:0] wr_data);
        int t0;
        wait_ready();
        drive(we, size, uns, addr, wdata);
        t0 = cyc;
        rsp_q.push_back('{rdata: exp_rdata, err: exp_err, cyc: t0 + lat});
        if (exp_wr) wr_q.push_back('{addr: {addr[31:2], 2'b00}, data: wr_data, cyc: t0 + wr_lat});
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("ready_low_t1", 32'(bus.req_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t;
        int n;
        for (int i = 0; i < 512; i++) ram[i] = 32'h0;
        ram[4]   = 32'h8899AABB;
        ram[511] = 32'hCAFEF00D;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_mem_a", bus.mem_a, 32'h0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_wd", bus.mem_wd, 32'h0);
        rst_n = 1'b1;

        // Loads: lb, lbu, lh, lhu, lb lane 0, lw at the top legal word.
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 2, 1'b0, 0, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 32'h00000099, 1'b0, 2, 1'b0, 0, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF8899, 1'b0, 2, 1'b0, 0, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000AABB, 1'b0, 2, 1'b0, 0, 32'h0);
        issue(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 1'b0, 0, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h7FC, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1'b0, 0, 32'h0);

        // Sub-word store (RMW), then read back.
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'hDEADBE55, 32'h0, 1'b0, 3, 1'b1, 2, 32'h889955BB);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h889955BB, 1'b0, 2, 1'b0, 0, 32'h0);

        // Word store, then read back.
        issue(1'b1, 2'b10, 1'b0, 32'h14, 32'h12345678, 32'h0, 1'b0, 2, 1'b1, 1, 32'h12345678);
        issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h12345678, 1'b0, 2, 1'b0, 0, 32'h0);

        // Errors: misaligned word, misaligned half, illegal size, out of range.
        issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1, 1'b0, 0, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF, 32'h0, 1'b1, 1, 1'b0, 0, 32'h0);
        issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1, 1'b0, 0, 32'h0);
        issue(1'b0, 2'b10, 1'b0, 32'h800, 32'h0, 32'h0, 1'b1, 1, 1'b0, 0, 32'h0);

        // Reset asserted during RMW_RD of sh 0x12: no write, no response.
        wait_ready();
        drive(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000CDEF);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_mem_we", 32'(bus.mem_we), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        check("rst_mid_ram", ram[4], 32'h889955BB);

        // req_valid held high: one acceptance per transaction, ready 1-0-0.
        wait_ready();
        drive(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        t = cyc;
        for (int k = 0; k < 4; k++)
            rsp_q.push_back('{rdata: 32'h12345678, err: 1'b0, cyc: t + 3*k + 2});
        for (int k = 0; k < 12; k++) begin
            if (k == 10) bus.req_valid = 1'b0;
            check("ready_pattern", 32'(bus.req_ready), (k % 3 == 0) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        n = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("rsp_queue_empty", rsp_q.size(), 32'd0);
        check("wr_queue_empty", wr_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
